wb_chan_regbank: RTL and testbench
==================================

# wb_chan_regbank

Parametrised Wishbone classic-pipelined register bank with N_CHAN identical channel groups. Each group has one 32-bit read/write control register and one read-only status register. It generalises the single-instance register/field-group bank with byte-lane writes, a per-channel write-strobe output, an optional sticky write-1-to-clear status mode, and bus error on unmapped addresses. It sits between the Wishbone interconnect and N_CHAN channel datapaths.

## Interface
- N_CHAN, 4: number of channel groups, 1..64
- ST_W, 2: status bits per channel, 1..32
- STICKY, 0: 1 = status latched, write-1-to-clear; 0 = status is a live view of status_i
- CTRL_RST, 32'h0: reset value of every control register
- AW: derived, clog2(2*N_CHAN), minimum 1
- clk_i  in  1  single clock, all logic on its rising edge
- rst_i  in  1  synchronous, active-high reset
- wb_cyc_i, wb_stb_i, wb_we_i  in  1  Wishbone control
- wb_adr_i  in  [AW+1:2]  word address
- wb_sel_i  in  4  byte lanes
- wb_dat_i  in  32  write data
- wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o  out  1  Wishbone response
- wb_dat_o  out  32  read data, registered
- ctrl_o  out  32*N_CHAN  control registers; channel k is bits [32k+31:32k]
- ctrl_wr_o  out  N_CHAN  one-cycle pulse when channel k's control register is written
- status_i  in  ST_W*N_CHAN  channel status inputs

## Operation
- Address map, word index w = wb_adr_i:
  - w = 2k: ctrl[k]
  - w = 2k+1: status[k]
  - w >= 2*N_CHAN: unmapped
- Request detect: en = cyc & stb. A read request is accepted only when no read is in progress (rip), and a write request only when no write is in progress (wip). rip/wip are set on acceptance and cleared on the response.
- Write path:
  - Accepted write registers req, address, data and sel (stage d0).
  - Next cycle decodes d0. For ctrl[k], bytes with sel=1 take the new data and other bytes keep their value.
- Status read: bits [ST_W-1:0] = status (live or latched), bits [31:ST_W] = 0.
- STICKY=1 behaviour:
  - Every cycle: lat <= (lat & ~clr) | status_i.
  - clr = wr_dat_d0 masked by sel lanes, applied only on the d0 write cycle to status[k].
  - Set wins over clear in the same cycle.
- STICKY=0: writes to a status address are acknowledged and ignored.
- Unmapped access: wb_err_o is asserted instead of wb_ack_o, at the same latency. Read data is 0 and no state changes.
- Outputs: wb_rty_o = 0 always; wb_stall_o = en & ~(ack|err).
- An accepted request always completes, even if cyc drops.

## Timing
- Read: request in cycle 0, address decoded combinationally, wb_dat_o/ack (or err) registered, asserted in cycle 1 for exactly one cycle.
- Write:
  - Request in cycle 0; d0 stage in cycle 1; ctrl_o updates at the edge ending cycle 1.
  - wb_ack_o/err and ctrl_wr_o[k] are high in cycle 2 for one cycle, so ack coincides with the new ctrl_o value.
- Back-to-back: the next read is accepted in the cycle after its ack (rip cleared), giving a throughput of 1 read per 2 cycles.
- Reset values:
  - ctrl_o = CTRL_RST replicated, ctrl_wr_o = 0, latched status = 0.
  - wb_dat_o = 0, wb_ack_o = wb_err_o = 0.
  - rip, wip and d0 stage = 0.
- Reset asserted mid-transaction: the pending transaction is dropped with no ack and no register update. The first request after reset deasserts follows the normal latency.
- Status sampling: a status_i pulse of at least one cycle is always captured when STICKY=1. A read returns the lat value as registered at the end of the previous cycle.

## Test plan
- Reset then read all addresses (N_CHAN=4) -> ctrl reads 32'h0, status reads status_i zero-extended, ack one cycle after each request, ack and err never high together.
- Write 32'hA5A5_1234 to w=4 (ctrl[2]) with sel=4'b0101, prior value 0 -> ctrl_o channel 2 = 32'h00A5_0034, ctrl_wr_o = 4'b0100 pulse together with ack in cycle 2, other channels unchanged.
- Access w=8 with N_CHAN=4, read and write -> wb_err_o in cycle 1 (read) / cycle 2 (write), wb_dat_o = 0, ctrl_o unchanged, wb_ack_o stays 0.
- STICKY=1, ST_W=2: pulse status_i[1:0] of channel 0 = 2'b01 for one cycle -> read w=1 returns 1. Write 32'h1 to w=1 while status_i = 2'b01 is driven again in the clear cycle -> bit stays 1 (set wins). Repeat with no set -> reads 0.
- Assert rst_i in cycle 1 of a write to ctrl[0] -> no ack, ctrl_o channel 0 = CTRL_RST. A new write after reset acks in cycle 2.
- Hold cyc/stb continuously for 4 reads -> exactly one ack per accepted request, stall high between acks, data matches the addressed register each time.

Source files
------------

// File: rtl/wb_chan_regbank.sv
// Wishbone classic-pipelined register bank: N_CHAN channels, each with a R/W
// control register (byte-lane writes, write strobe) and a live or sticky-W1C status register.
module wb_chan_regbank #(
  parameter int          N_CHAN   = 4,
  parameter int          ST_W     = 2,
  parameter bit          STICKY   = 1'b0,
  parameter logic [31:0] CTRL_RST = 32'h0,
  parameter int          AW       = ($clog2(2*N_CHAN) < 1) ? 1 : $clog2(2*N_CHAN)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_we_i,
  input  logic [AW+1:2]          wb_adr_i,
  input  logic [3:0]             wb_sel_i,
  input  logic [31:0]            wb_dat_i,
  output logic                   wb_ack_o,
  output logic                   wb_err_o,
  output logic                   wb_rty_o,
  output logic                   wb_stall_o,
  output logic [31:0]            wb_dat_o,
  output logic [32*N_CHAN-1:0]   ctrl_o,
  output logic [N_CHAN-1:0]      ctrl_wr_o,
  input  logic [ST_W*N_CHAN-1:0] status_i
);

  localparam logic [31:0] N_WORDS = 32'(2*N_CHAN);

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{sel[b]}};
    return m;
  endfunction

  logic          en, rd_acc, wr_acc;
  logic          rip, wip, rd_done_q, wr_done_q;
  logic          wr_req_d0;
  logic [AW-1:0] adr_d0;
  logic [31:0]   dat_d0;
  logic [3:0]    sel_d0;
  logic [31:0]   wr_mask, wr_dat_m;
  logic          rd_unmapped, wr_unmapped;
  logic [31:0]   rd_data;
  logic [31:0]   ctrl_q  [N_CHAN];
  logic [ST_W-1:0] st_view [N_CHAN];

  assign en     = wb_cyc_i & wb_stb_i;
  assign rd_acc = en & ~wb_we_i & ~rip;
  assign wr_acc = en &  wb_we_i & ~wip;

  assign wr_mask     = lane_mask(sel_d0);
  assign wr_dat_m    = dat_d0 & wr_mask;
  assign rd_unmapped = 32'(wb_adr_i) >= N_WORDS;
  assign wr_unmapped = 32'(adr_d0) >= N_WORDS;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N_CHAN; k++) begin
      if (wb_adr_i == AW'(2*k))
        rd_data = ctrl_q[k];
      if (wb_adr_i == AW'(2*k+1))
        rd_data[ST_W-1:0] = st_view[k];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples values from before the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rip       <= 1'b0;
      wip       <= 1'b0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      wr_req_d0 <= 1'b0;
      adr_d0    <= '0;
      dat_d0    <= '0;
      sel_d0    <= '0;
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
      wb_dat_o  <= '0;
    end else begin
      rd_done_q <= rd_acc;
      wr_done_q <= wr_req_d0;
      rip       <= rd_acc | (rip & ~rd_done_q);
      wip       <= wr_acc | (wip & ~wr_done_q);
      wr_req_d0 <= wr_acc;
      if (wr_acc) begin
        adr_d0 <= wb_adr_i;
        dat_d0 <= wb_dat_i;
        sel_d0 <= wb_sel_i;
      end
      wb_ack_o <= (rd_acc & ~rd_unmapped) | (wr_req_d0 & ~wr_unmapped);
      wb_err_o <= (rd_acc &  rd_unmapped) | (wr_req_d0 &  wr_unmapped);
      wb_dat_o <= rd_acc ? rd_data : '0;
    end
  end

  // NOTE: the control array is a handful of flops, not a RAM, so it takes a reset value like any other register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_wr_o <= '0;
      for (int k = 0; k < N_CHAN; k++) ctrl_q[k] <= CTRL_RST;
    end else begin
      ctrl_wr_o <= '0;
      for (int k = 0; k < N_CHAN; k++) begin
        if (wr_req_d0 && adr_d0 == AW'(2*k)) begin
          ctrl_q[k]    <= (ctrl_q[k] & ~wr_mask) | wr_dat_m;
          ctrl_wr_o[k] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    ctrl_o = '0;
    for (int k = 0; k < N_CHAN; k++) ctrl_o[32*k +: 32] = ctrl_q[k];
  end

  if (STICKY) begin : g_sticky
    logic [ST_W-1:0] lat_q [N_CHAN];
    logic [ST_W-1:0] clr   [N_CHAN];

    always_comb begin
      for (int k = 0; k < N_CHAN; k++) begin
        clr[k] = '0;
        if (wr_req_d0 && adr_d0 == AW'(2*k+1)) clr[k] = wr_dat_m[ST_W-1:0];
      end
    end

    // New events are OR-ed in after the clear, so a set in the clear cycle survives.
    always_ff @(posedge clk_i) begin
      for (int k = 0; k < N_CHAN; k++) begin
        if (rst_i) lat_q[k] <= '0;
        else       lat_q[k] <= (lat_q[k] & ~clr[k]) | status_i[k*ST_W +: ST_W];
      end
    end

    always_comb begin
      for (int k = 0; k < N_CHAN; k++) st_view[k] = lat_q[k];
    end
  end else begin : g_live
    always_comb begin
      for (int k = 0; k < N_CHAN; k++) st_view[k] = status_i[k*ST_W +: ST_W];
    end
  end

  assign wb_rty_o   = 1'b0;
  assign wb_stall_o = en & ~(wb_ack_o | wb_err_o);

endmodule

// File: tb/tb_wb_chan_regbank.sv
// Scoreboard bench for wb_chan_regbank: a live-status and a sticky-status
// instance share one bus; a negedge monitor pops expected responses and compares.
module tb_wb_chan_regbank;

  localparam logic [31:0] RST_S = 32'h1234_5678;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [3:0]   wb_adr = '0;
  logic [3:0]   wb_sel = '0;
  logic [31:0]  wb_dat = '0;
  logic [7:0]   st = 8'b10_01_11_00;

  logic         ack_l, err_l, rty_l, stall_l, ack_s, err_s, rty_s, stall_s;
  logic [31:0]  dat_l, dat_s;
  logic [127:0] ctrl_l, ctrl_s;
  logic [3:0]   wr_l, wr_s;

  wb_chan_regbank #(.N_CHAN(4), .ST_W(2), .STICKY(1'b0), .CTRL_RST(32'h0), .AW(4)) dut_live (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
    .wb_adr_i(wb_adr), .wb_sel_i(wb_sel), .wb_dat_i(wb_dat),
    .wb_ack_o(ack_l), .wb_err_o(err_l), .wb_rty_o(rty_l), .wb_stall_o(stall_l),
    .wb_dat_o(dat_l), .ctrl_o(ctrl_l), .ctrl_wr_o(wr_l), .status_i(st));

  wb_chan_regbank #(.N_CHAN(4), .ST_W(2), .STICKY(1'b1), .CTRL_RST(RST_S), .AW(4)) dut_stk (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
    .wb_adr_i(wb_adr), .wb_sel_i(wb_sel), .wb_dat_i(wb_dat),
    .wb_ack_o(ack_s), .wb_err_o(err_s), .wb_rty_o(rty_s), .wb_stall_o(stall_s),
    .wb_dat_o(dat_s), .ctrl_o(ctrl_s), .ctrl_wr_o(wr_s), .status_i(st));

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    bit [95:0]    tag;
    bit           err;
    bit           chk_dat;
    logic [31:0]  dat_l;
    logic [31:0]  dat_s;
    logic [127:0] ctrl_l;
    logic [127:0] ctrl_s;
    logic [3:0]   wr;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         cur;
  int           n_vec = 0, n_mis = 0, resp_cnt = 0;
  logic [127:0] mc_l, mc_s;

  task automatic check(input bit [95:0] tag, input bit [63:0] field,
                       input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %0s.%0s: got %0h expected %0h (cycle %0d)", tag, field, act, exp, cyc_cnt);
    end
  endtask

  task automatic proto_fail(input bit [63:0] what);
    n_mis++;
    $display("FAIL proto.%0s at cycle %0d", what, cyc_cnt);
  endtask

  function automatic void push_exp(input bit [95:0] tag, input bit err, input bit chk_dat,
                                   input logic [31:0] e_l, input logic [31:0] e_s,
                                   input logic [3:0] e_wr, input int at_cyc);
    exp_t e;
    e.tag = tag; e.err = err; e.chk_dat = chk_dat;
    e.dat_l = e_l; e.dat_s = e_s; e.wr = e_wr; e.cyc = at_cyc;
    e.ctrl_l = mc_l; e.ctrl_s = mc_s;
    sb.push_back(e);
  endfunction

  // One isolated request; called #1 after a rising edge, returns #1 after the edge following its response.
  task automatic do_req(input bit we, input logic [3:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input bit e_err, input bit chk_dat,
                        input logic [31:0] e_l, input logic [31:0] e_s,
                        input logic [3:0] e_wr, input bit [95:0] tag);
    int start;
    push_exp(tag, e_err, chk_dat, e_l, e_s, e_wr, cyc_cnt + (we ? 2 : 1));
    start  = resp_cnt;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
    wb_adr = adr;  wb_sel = sel;  wb_dat = dat;
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    for (int i = 0; i < 8 && resp_cnt == start; i++) @(posedge clk);
    #1;
    if (resp_cnt == start) begin
      n_vec++; n_mis++;
      $display("FAIL %0s.timeout: no response within 8 cycles", tag);
      if (sb.size() > 0) void'(sb.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if ((ack_l && err_l) || (ack_s && err_s)) proto_fail("ack+err");
      if (rty_l || rty_s) proto_fail("rty");
      if (stall_l !== ((wb_cyc && wb_stb) && !(ack_l || err_l))) proto_fail("stall_l");
      if (stall_s !== ((wb_cyc && wb_stb) && !(ack_s || err_s))) proto_fail("stall_s");
      if (!(ack_l || err_l) && wr_l != 4'b0) proto_fail("wr_l");
      if (!(ack_s || err_s) && wr_s != 4'b0) proto_fail("wr_s");
      if (ack_l || err_l || ack_s || err_s) begin
        if (sb.size() == 0) proto_fail("unexpctd");
        else begin
          cur = sb.pop_front();
          check(cur.tag, "cycle",  128'(cyc_cnt), 128'(cur.cyc));
          check(cur.tag, "ack_l",  128'(ack_l),   128'(!cur.err));
          check(cur.tag, "err_l",  128'(err_l),   128'(cur.err));
          check(cur.tag, "ack_s",  128'(ack_s),   128'(!cur.err));
          check(cur.tag, "err_s",  128'(err_s),   128'(cur.err));
          if (cur.chk_dat) begin
            check(cur.tag, "dat_l", 128'(dat_l), 128'(cur.dat_l));
            check(cur.tag, "dat_s", 128'(dat_s), 128'(cur.dat_s));
          end
          check(cur.tag, "ctrl_l", ctrl_l,      cur.ctrl_l);
          check(cur.tag, "ctrl_s", ctrl_s,      cur.ctrl_s);
          check(cur.tag, "wr_l",   128'(wr_l),  128'(cur.wr));
          check(cur.tag, "wr_s",   128'(wr_s),  128'(cur.wr));
          resp_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mc_l = '0;
    mc_s = {4{RST_S}};
    repeat (3) @(posedge clk);
    #1;
    check("reset", "ctrl_l", ctrl_l, mc_l);
    check("reset", "ctrl_s", ctrl_s, mc_s);
    check("reset", "resp", 128'({ack_l, err_l, ack_s, err_s, wr_l, wr_s}), 128'(0));
    check("reset", "dat", 128'({dat_l, dat_s}), 128'(0));
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Read every mapped word after reset.
    do_req(0, 4'd0, 4'hF, 32'h0, 0, 1, 32'h0, RST_S, 4'b0, "rd_c0");
    do_req(0, 4'd1, 4'hF, 32'h0, 0, 1, 32'h0, 32'h0, 4'b0, "rd_s0");
    do_req(0, 4'd2, 4'hF, 32'h0, 0, 1, 32'h0, RST_S, 4'b0, "rd_c1");
    do_req(0, 4'd3, 4'hF, 32'h0, 0, 1, 32'h3, 32'h3, 4'b0, "rd_s1");
    do_req(0, 4'd4, 4'hF, 32'h0, 0, 1, 32'h0, RST_S, 4'b0, "rd_c2");
    do_req(0, 4'd5, 4'hF, 32'h0, 0, 1, 32'h1, 32'h1, 4'b0, "rd_s2");
    do_req(0, 4'd6, 4'hF, 32'h0, 0, 1, 32'h0, RST_S, 4'b0, "rd_c3");
    do_req(0, 4'd7, 4'hF, 32'h0, 0, 1, 32'h2, 32'h2, 4'b0, "rd_s3");

    // Byte-lane writes.
    mc_l[95:64] = 32'h00A5_0034; mc_s[95:64] = 32'h12A5_5634;
    do_req(1, 4'd4, 4'b0101, 32'hA5A5_1234, 0, 0, 32'h0, 32'h0, 4'b0100, "wr_c2_0101");
    do_req(0, 4'd4, 4'hF, 32'h0, 0, 1, 32'h00A5_0034, 32'h12A5_5634, 4'b0, "rd_c2_new");
    mc_l[127:96] = 32'hDEAD_BEEF; mc_s[127:96] = 32'hDEAD_BEEF;
    do_req(1, 4'd6, 4'b1111, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0, 4'b1000, "wr_c3_all");
    mc_l[127:96] = 32'h11AD_BEEF; mc_s[127:96] = 32'h11AD_BEEF;
    do_req(1, 4'd6, 4'b1000, 32'h1122_3344, 0, 0, 32'h0, 32'h0, 4'b1000, "wr_c3_b3");
    do_req(0, 4'd6, 4'hF, 32'h0, 0, 1, 32'h11AD_BEEF, 32'h11AD_BEEF, 4'b0, "rd_c3_new");

    // Unmapped accesses.
    do_req(0, 4'd8,  4'hF, 32'h0,         1, 1, 32'h0, 32'h0, 4'b0, "rd_unmap8");
    do_req(1, 4'd8,  4'hF, 32'hFFFF_FFFF, 1, 1, 32'h0, 32'h0, 4'b0, "wr_unmap8");
    do_req(0, 4'd15, 4'hF, 32'h0,         1, 1, 32'h0, 32'h0, 4'b0, "rd_unmap15");

    // Status write with the event still present: live ignores it, sticky keeps it.
    do_req(1, 4'd3, 4'hF, 32'h3, 0, 0, 32'h0, 32'h0, 4'b0, "wr_s1");
    do_req(0, 4'd3, 4'hF, 32'h0, 0, 1, 32'h3, 32'h3, 4'b0, "rd_s1_keep");

    // One-cycle pulse on channel 0 status.
    st[1:0] = 2'b01;
    @(posedge clk); #1;
    st[1:0] = 2'b00;
    @(posedge clk); #1;
    do_req(0, 4'd1, 4'hF, 32'h0, 0, 1, 32'h0, 32'h1, 4'b0, "rd_s0_pulse");

    // Clear while the event recurs in the clear cycle: set wins.
    fork
      do_req(1, 4'd1, 4'b0001, 32'h1, 0, 0, 32'h0, 32'h0, 4'b0, "w1c_setwin");
      begin
        @(posedge clk); #1 st[1:0] = 2'b01;
        @(posedge clk); #1 st[1:0] = 2'b00;
      end
    join
    do_req(0, 4'd1, 4'hF, 32'h0, 0, 1, 32'h0, 32'h1, 4'b0, "rd_s0_set");
    do_req(1, 4'd1, 4'b0001, 32'h1, 0, 0, 32'h0, 32'h0, 4'b0, "w1c_clear");
    do_req(0, 4'd1, 4'hF, 32'h0, 0, 1, 32'h0, 32'h0, 4'b0, "rd_s0_clr");

    // Reset during the d0 cycle of a write to ctrl[0]: dropped, no ack.
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    wb_adr = 4'd0; wb_sel = 4'hF; wb_dat = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mc_l = '0;
    mc_s = {4{RST_S}};
    check("rst_mid", "ctrl0_l", 128'(ctrl_l[31:0]), 128'(32'h0));
    check("rst_mid", "ctrl0_s", 128'(ctrl_s[31:0]), 128'(RST_S));
    check("rst_mid", "ctrl_s", ctrl_s, mc_s);
    mc_l[31:0] = 32'h0000_00FF; mc_s[31:0] = 32'h1234_56FF;
    do_req(1, 4'd0, 4'b0001, 32'hCAFE_BAFF, 0, 0, 32'h0, 32'h0, 4'b0001, "wr_c0_post");

    // cyc/stb held for four reads: accepted every other cycle.
    push_exp("burst0", 0, 1, 32'h0000_00FF, 32'h1234_56FF, 4'b0, cyc_cnt + 1);
    push_exp("burst1", 0, 1, 32'h3,         32'h3,         4'b0, cyc_cnt + 3);
    push_exp("burst2", 0, 1, 32'h0,         RST_S,         4'b0, cyc_cnt + 5);
    push_exp("burst3", 0, 1, 32'h2,         32'h2,         4'b0, cyc_cnt + 7);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF;
    wb_adr = 4'd0; repeat (2) @(posedge clk); #1;
    wb_adr = 4'd3; repeat (2) @(posedge clk); #1;
    wb_adr = 4'd4; repeat (2) @(posedge clk); #1;
    wb_adr = 4'd7; repeat (2) @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("final", "sb_left", 128'(sb.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
